matrix_nxn_buff: RTL
====================

# matrix_nxn_buff

Parametrised, double-buffered operand collector for the fixed-point matrix multiplier. It deserialises two element streams into an N×N A matrix and an N×N B matrix, then presents both as complete matrices to the multiply array. Two ping-pong banks let the next matrix pair load while the current pair waits to be consumed, so there are no dead cycles between frames. It also adds a per-frame B-transpose mode and frame-length error detection.

## Interface
- W, 12, element width (fixed-point 12:10 by default; the block is format-agnostic)
- N, 4, matrix dimension; legal range 2..8
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- a_in  in  W  A element of current beat
- b_in  in  W  B element of current beat
- s_last  in  1  marks the final beat of a frame (beat N*N-1)
- b_trans  in  1  frame mode; sampled on beat 0 of each frame
- m_valid  out  1  complete matrix pair available
- m_ready  in  1  consumer accepts the pair
- a_mat  out  N*N*W  A matrix; element (r,c) at bits [(c*N+r)*W +: W]
- b_mat  out  N*N*W  B matrix; same packing as a_mat
- frame_err  out  1  one-cycle pulse on a framing error

## Operation
- A beat is accepted when s_valid && s_ready. The beat index k runs 0..N*N-1 and resets to 0 at frame end.
- Input order is column-major: k = c*N + r.
  - A element k is written to A(r,c).
  - If the frame's b_trans = 0, B element k is written to B(r,c).
  - If b_trans = 1, B element k is written to B(c,r).
- The b_trans value is latched on beat 0 and held for the whole frame. Changes on later beats are ignored.
- Two banks, 0 and 1. State:
  - wr_bank: the bank being filled.
  - rd_bank: the bank being presented.
  - full[1:0]: per-bank full flag.
  - k: beat counter, width $clog2(N*N).
- s_ready = !full[wr_bank]. This is combinational from registers only, with no path from s_valid.
- Frame completion, when beat k = N*N-1 is accepted with s_last = 1:
  - full[wr_bank] <= 1
  - wr_bank toggles
  - k <= 0
- Early last: s_last = 1 on a beat with k < N*N-1.
  - The beat is written.
  - The partial frame is discarded: k <= 0, the bank is not marked full, and wr_bank is unchanged.
  - frame_err pulses.
- Missing last: s_last = 0 on beat N*N-1.
  - The beat is written.
  - The frame is discarded the same way and frame_err pulses.
- m_valid = full[rd_bank]. a_mat and b_mat are driven directly from bank rd_bank.
- Release occurs when m_valid && m_ready: full[rd_bank] <= 0 and rd_bank toggles.
- Completion and release in the same cycle act on different banks. Both take effect, with no priority conflict.
- While m_valid = 1, a_mat and b_mat are stable until release.
- Outputs when m_valid = 0 are don't-care, except immediately after reset.
- Bank contents are not cleared between frames. Every element is overwritten by a valid frame.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - k = 0, wr_bank = 0, rd_bank = 0, full = 2'b00
  - all bank storage = 0
  - latched b_trans = 0
  - Resulting outputs: s_ready = 1, m_valid = 0, frame_err = 0, a_mat = 0, b_mat = 0.
- Reset asserted mid-frame or mid-presentation discards all data. There is no partial recovery.
- Latency: the final beat is accepted at edge t, and m_valid = 1 in the cycle after edge t.
- Throughput: with m_ready held at 1, s_ready stays at 1 and one frame per N*N cycles is sustained with no bubbles.
- Back-pressure:
  - When both banks are full, s_ready = 0.
  - s_ready returns to 1 in the cycle after the release edge.
  - The release and the next write cannot hit the same bank in the same cycle.
- frame_err is registered: it is high for exactly one cycle following the offending edge.
- Storage: 2 × 2 × N*N × W flops. Write-side decode uses k, with the transposed index (r*N + c) for B when b_trans = 1.

## Test plan
- Reset value check: hold rst_n = 0, then release. Required: s_ready = 1, m_valid = 0, frame_err = 0, a_mat = 0, b_mat = 0.
- Normal frame (N=4, W=12, b_trans = 0):
  - Stimulus: 16 beats with a_in = k, b_in = 16+k, s_last on k = 15, m_ready = 0.
  - Required: m_valid rises the cycle after beat 15; A(1,2) = 9; B(3,0) = 19.
- Transpose frame: same stream with b_trans = 1 on beat 0. Required: B(0,3) = 19, B(2,1) = 25; A is unchanged from the normal case.
- Ping-pong and back-pressure:
  - Stimulus: 3 frames back-to-back with m_ready = 0.
  - Required: s_ready drops after frame 2; frame 3 stalls.
  - Then pulse m_ready for 1 cycle. Required: frame 1 is released, frame 2 is presented, s_ready returns the next cycle, and frame 3 completes.
- Streaming: 8 frames with m_ready = 1 and s_valid = 1 continuously. Required: s_ready never drops; 8 m_valid handshakes occur, one every 16 cycles; data matches in order.
- Framing errors:
  - s_last on k = 5: frame_err pulses once, no m_valid, and the next good frame loads correctly.
  - No s_last on k = 15: frame_err pulses once and the frame is dropped.
  - rst_n pulsed at k = 7: all state is cleared, and a subsequent full frame is presented correctly.

Source files
------------

// File: rtl/matrix_nxn_buff.sv
// matrix_nxn_buff: double-buffered N x N operand collector with per-frame B-transpose and framing checks
module matrix_nxn_buff #(
  parameter int W = 12,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             s_last,
  input  logic             b_trans,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*N*W-1:0] a_mat,
  output logic [N*N*W-1:0] b_mat,
  output logic             frame_err
);
  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
  logic [NN*W-1:0] a_bank [2];
  logic [NN*W-1:0] b_bank [2];
  logic [KW-1:0] k;
  logic [KW-1:0] kb;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic wr_bank;
  logic rd_bank;
  logic trans_q;
  logic tr;
  logic acc;
  logic last_k;
  logic done;
  logic rel;
  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign a_mat = a_bank[rd_bank];
  assign b_mat = b_bank[rd_bank];
  assign acc = s_valid && s_ready;
  assign last_k = k == K_LAST;
  assign done = acc && last_k && s_last;
  assign rel = m_valid && m_ready;
  // beat 0 uses the live b_trans, later beats the value latched on beat 0
  assign tr = (k == '0) ? b_trans : trans_q;
  assign kb = tr ? KW'((int'(k) % N) * N + int'(k) / N) : k;
  // completion and release can never target the same bank, so both apply
  always_comb begin
    full_nxt = full;
    if (done) full_nxt[wr_bank] = 1'b1;
    if (rel) full_nxt[rd_bank] = 1'b0;
  end
  // beat counter, bank pointers, full flags and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      full <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      trans_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      full <= full_nxt;
      frame_err <= acc && (s_last != last_k);
      if (acc) k <= (s_last || last_k) ? '0 : k + 1'b1;
      if (acc && k == '0) trans_q <= b_trans;
      if (done) wr_bank <= !wr_bank;
      if (rel) rd_bank <= !rd_bank;
    end
  end
  // element storage; discarded frames still write, valid frames overwrite every element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_bank[0] <= '0;
      a_bank[1] <= '0;
      b_bank[0] <= '0;
      b_bank[1] <= '0;
    end else if (acc) begin
      a_bank[wr_bank][int'(k)*W +: W] <= a_in;
      b_bank[wr_bank][int'(kb)*W +: W] <= b_in;
    end
  end
endmodule
